// File: rtl/kyber_rej_sampler.sv
// kyber_rej_sampler: ML-KEM SampleNTT uniform rejection sampler fed by shake128_top.
// Splits 64-bit LE squeeze words into 12-bit LSB-first candidates and emits the first N below Q.
module kyber_rej_sampler #(
    parameter int Q  = 3329,
    parameter int N  = 256,
    parameter int CW = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [63:0]          i_data,
    input  logic                 i_valid,
    output logic                 o_ack,
    output logic [CW-1:0]        o_coef,
    output logic                 o_coef_valid,
    input  logic                 i_coef_ready,
    output logic [$clog2(N)-1:0] o_coef_idx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int WW   = 64;
    localparam int BW   = WW + CW;
    localparam int CNTW = $clog2(BW);
    localparam int IW   = $clog2(N);

    localparam logic [CW-1:0]   Q_L      = CW'(Q);
    localparam logic [CNTW-1:0] CW_L     = CNTW'(CW);
    localparam logic [CNTW-1:0] WW_L     = CNTW'(WW);
    localparam logic [IW-1:0]   LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [BW-1:0]   bit_buf;
    logic [CNTW-1:0] cnt;
    logic [IW-1:0]   acc_cnt;
    logic            ack_prev;

    logic            xfer;
    logic            last_pending;
    logic            last_xfer;
    logic            enter_run;
    logic            load;
    logic            extract;
    logic [CW-1:0]   cand;
    logic            accept;

    // Once the final coefficient is waiting for its handshake no more words are pulled.
    always_comb begin
        xfer         = o_coef_valid && i_coef_ready;
        last_pending = o_coef_valid && (acc_cnt == LAST_IDX);
        last_xfer    = xfer && last_pending;
        enter_run    = i_start && ((state == IDLE) || (state == DONE));
        load         = (state == RUN) && (cnt < CW_L) && i_valid && !ack_prev && !last_pending;
        extract      = (state == RUN) && (cnt >= CW_L) && (!o_coef_valid || i_coef_ready) && !last_xfer;
        cand         = bit_buf[CW-1:0];
        accept       = cand < Q_L;
    end

    assign o_ack  = load;
    assign o_busy = (state == RUN);
    assign o_done = (state == DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (i_start) state_next = RUN;
            RUN:  if (last_xfer) state_next = DONE;
            DONE: if (i_start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_buf      <= '0;
            cnt          <= '0;
            acc_cnt      <= '0;
            ack_prev     <= 1'b0;
            o_coef       <= '0;
            o_coef_idx   <= '0;
            o_coef_valid <= 1'b0;
        end else begin
            ack_prev <= load;
            if (enter_run) begin
                bit_buf      <= '0;
                cnt          <= '0;
                acc_cnt      <= '0;
                o_coef_valid <= 1'b0;
            end else if (state == RUN) begin
                if (xfer) begin
                    acc_cnt <= acc_cnt + IW'(1);
                end

                // cnt < CW for a load and cnt >= CW for an extract, so the two never collide.
                if (load) begin
                    bit_buf <= bit_buf | (BW'(i_data) << cnt);
                    cnt     <= cnt + WW_L;
                end else if (extract) begin
                    bit_buf <= bit_buf >> CW;
                    cnt     <= cnt - CW_L;
                end

                if (extract) begin
                    if (accept) begin
                        o_coef       <= cand;
                        o_coef_idx   <= acc_cnt + IW'(xfer);
                        o_coef_valid <= 1'b1;
                    end else begin
                        o_coef_valid <= 1'b0;
                    end
                end else if (xfer) begin
                    o_coef_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_kyber_rej_sampler.sv
// tb_kyber_rej_sampler: drives squeeze-word streams into kyber_rej_sampler and checks
// the emitted coefficients against a bit-list model of the SampleNTT rejection rule.
module tb_kyber_rej_sampler;

    localparam int Q  = 3329;
    localparam int N  = 256;
    localparam int CW = 12;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [63:0] i_data;
    logic        i_valid;
    logic        o_ack;
    logic [11:0] o_coef;
    logic        o_coef_valid;
    logic        i_coef_ready;
    logic [7:0]  o_coef_idx;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int passes = 0;

    logic [63:0] words[$];
    int          widx;
    int          acks;
    int          got_coef[$];
    int          got_idx[$];
    int          exp_coef[$];
    int          words_needed;

    kyber_rej_sampler #(.Q(Q), .N(N), .CW(CW)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ack       (o_ack),
        .o_coef      (o_coef),
        .o_coef_valid(o_coef_valid),
        .i_coef_ready(i_coef_ready),
        .o_coef_idx  (o_coef_idx),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Reference: flatten the words into a bit list, cut 12-bit candidates, keep those below Q.
    task automatic build_model();
        bit bits[$];
        int val;
        exp_coef.delete();
        words_needed = -1;
        foreach (words[w]) begin
            for (int b = 0; b < 64; b++) bits.push_back(words[w][b]);
            while (bits.size() >= CW && exp_coef.size() < N) begin
                val = 0;
                for (int j = 0; j < CW; j++) val += int'(bits.pop_front()) << j;
                if (val < Q) exp_coef.push_back(val);
            end
            if (exp_coef.size() == N && words_needed < 0) words_needed = w + 1;
        end
    endtask

    task automatic do_reset();
        i_rst_n      = 1'b0;
        i_start      = 1'b0;
        i_valid      = 1'b0;
        i_data       = 64'h0;
        i_coef_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit valid_en, input bit ready);
        bit acked;
        i_valid      = valid_en && (widx < words.size());
        i_data       = (widx < words.size()) ? words[widx] : 64'h0;
        i_coef_ready = ready;
        #1;
        acked = o_ack;
        if (o_coef_valid && ready) begin
            got_coef.push_back(int'(o_coef));
            got_idx.push_back(int'(o_coef_idx));
        end
        @(posedge i_clk);
        if (acked) begin
            acks++;
            widx++;
        end
        @(negedge i_clk);
    endtask

    task automatic start_run();
        widx = 0;
        acks = 0;
        got_coef.delete();
        got_idx.delete();
        build_model();
        i_start = 1'b1;
        step(1'b0, 1'b0);
        i_start = 1'b0;
    endtask

    task automatic run_until(input int max_cycles, input int ready_pct, input int valid_pct,
                             input int xfer_limit, input int ack_limit, output bit timed_out);
        int n;
        n = 0;
        timed_out = 1'b0;
        while (!o_done && got_coef.size() < xfer_limit && acks < ack_limit) begin
            if (n == max_cycles) begin
                timed_out = 1'b1;
                break;
            end
            step($urandom_range(99) < valid_pct, $urandom_range(99) < ready_pct);
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_ack, o_coef_valid, o_busy, o_done} !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b expected 0000", {o_ack, o_coef_valid, o_busy, o_done});
        else passes++;
        checks++;
        if (o_coef !== 12'h0) $display("[TB] FAIL reset_coef: got %0d expected 0", o_coef);
        else passes++;
        checks++;
        if (o_coef_idx !== 8'h0) $display("[TB] FAIL reset_idx: got %0d expected 0", o_coef_idx);
        else passes++;
    endtask

    task automatic test_zero_words();
        bit to;
        words.delete();
        repeat (60) words.push_back(64'h0);
        do_reset();
        start_run();
        run_until(3000, 100, 100, N + 1, 1000, to);
        checks++;
        if (to) $display("[TB] FAIL zero_timeout: got no done expected done within budget");
        else passes++;
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0)
            $display("[TB] FAIL zero_done: got done=%b busy=%b expected done=1 busy=0", o_done, o_busy);
        else passes++;
        repeat (10) step(1'b1, 1'b1);
        checks++;
        if (acks !== words_needed) $display("[TB] FAIL zero_acks: got %0d expected %0d", acks, words_needed);
        else passes++;
        checks++;
        if (got_coef.size() != N) $display("[TB] FAIL zero_count: got %0d expected %0d", got_coef.size(), N);
        else passes++;
        for (int i = 0; i < got_coef.size() && i < N; i++) begin
            checks++;
            if (got_coef[i] !== exp_coef[i] || got_idx[i] !== i)
                $display("[TB] FAIL zero_coef[%0d]: got %0d@%0d expected %0d@%0d", i, got_coef[i], got_idx[i], exp_coef[i], i);
            else passes++;
        end
    endtask

    task automatic test_all_ones();
        bit to;
        words.delete();
        repeat (100) words.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        do_reset();
        start_run();
        run_until(2000, 100, 100, 1, 100, to);
        repeat (10) step(1'b1, 1'b1);
        checks++;
        if (to || acks !== 100) $display("[TB] FAIL ones_acks: got %0d (timeout=%0b) expected 100", acks, to);
        else passes++;
        checks++;
        if (got_coef.size() != 0) $display("[TB] FAIL ones_count: got %0d expected 0", got_coef.size());
        else passes++;
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b1)
            $display("[TB] FAIL ones_state: got done=%b busy=%b expected done=0 busy=1", o_done, o_busy);
        else passes++;
    endtask

    task automatic test_q_boundary();
        bit to;
        words.delete();
        words.push_back(64'h0000_0000_00D0_1D00);
        repeat (59) words.push_back(64'h0);
        do_reset();
        start_run();
        run_until(500, 100, 100, 3, 1000, to);
        checks++;
        if (got_coef.size() < 3) $display("[TB] FAIL bound_count: got %0d expected 3", got_coef.size());
        else begin
            passes++;
            checks++;
            if (got_coef[0] !== 3328 || got_idx[0] !== 0)
                $display("[TB] FAIL bound_q_minus_1: got %0d@%0d expected 3328@0", got_coef[0], got_idx[0]);
            else passes++;
            checks++;
            if (got_coef[1] !== 0 || got_idx[1] !== 1)
                $display("[TB] FAIL bound_after_reject: got %0d@%0d expected 0@1", got_coef[1], got_idx[1]);
            else passes++;
        end
    endtask

    task automatic test_straddle();
        bit to;
        int bad;
        words.delete();
        words.push_back(64'h5000_0000_0000_0000);
        words.push_back(64'h0000_0000_0000_0012);
        repeat (58) words.push_back(64'h0);
        do_reset();
        start_run();
        run_until(500, 100, 100, 6, 1000, to);
        checks++;
        if (got_coef.size() < 6) $display("[TB] FAIL straddle_count: got %0d expected 6", got_coef.size());
        else begin
            passes++;
            bad = 0;
            for (int i = 0; i < 5; i++) if (got_coef[i] !== 0 || got_idx[i] !== i) bad++;
            checks++;
            if (bad != 0) $display("[TB] FAIL straddle_zeros: got %0d bad entries expected 0", bad);
            else passes++;
            checks++;
            if (got_coef[5] !== 293 || got_idx[5] !== 5)
                $display("[TB] FAIL straddle_coef: got %0d@%0d expected 293@5", got_coef[5], got_idx[5]);
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int drift;
        words.delete();
        repeat (60) words.push_back(64'h0);
        do_reset();
        start_run();
        drift = 0;
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 1'b0);
            if (c >= 2 && (o_coef_valid !== 1'b1 || o_coef_idx !== 8'd0)) drift++;
        end
        checks++;
        if (drift != 0) $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", drift);
        else passes++;
        checks++;
        if (acks !== 1) $display("[TB] FAIL bp_acks: got %0d expected 1", acks);
        else passes++;
        repeat (5) step(1'b1, 1'b1);
        checks++;
        if (got_idx.size() != 5) $display("[TB] FAIL bp_release_count: got %0d expected 5", got_idx.size());
        else passes++;
        for (int i = 0; i < got_idx.size() && i < 5; i++) begin
            checks++;
            if (got_idx[i] !== i) $display("[TB] FAIL bp_release_idx[%0d]: got %0d expected %0d", i, got_idx[i], i);
            else passes++;
        end
        run_until(3000, 100, 100, N + 1, 1000, to);
        checks++;
        if (to || got_coef.size() != N || acks !== words_needed)
            $display("[TB] FAIL bp_complete: got %0d coefs %0d acks expected %0d coefs %0d acks", got_coef.size(), acks, N, words_needed);
        else passes++;
    endtask

    task automatic test_random();
        bit to;
        int rp[3] = '{100, 50, 70};
        int vp[3] = '{50, 100, 70};
        for (int it = 0; it < 3; it++) begin
            words.delete();
            repeat (100) words.push_back({$urandom(), $urandom()});
            do_reset();
            start_run();
            run_until(8000, rp[it], vp[it], N + 1, 1000, to);
            checks++;
            if (to || o_done !== 1'b1) $display("[TB] FAIL rand%0d_done: got done=%b timeout=%0b expected done=1", it, o_done, to);
            else passes++;
            checks++;
            if (acks !== words_needed) $display("[TB] FAIL rand%0d_acks: got %0d expected %0d", it, acks, words_needed);
            else passes++;
            checks++;
            if (got_coef.size() != N) $display("[TB] FAIL rand%0d_count: got %0d expected %0d", it, got_coef.size(), N);
            else passes++;
            for (int i = 0; i < got_coef.size() && i < N; i++) begin
                checks++;
                if (got_coef[i] !== exp_coef[i] || got_idx[i] !== i)
                    $display("[TB] FAIL rand%0d_coef[%0d]: got %0d@%0d expected %0d@%0d", it, i, got_coef[i], got_idx[i], exp_coef[i], i);
                else passes++;
            end
        end
    endtask

    task automatic test_async_reset();
        bit to;
        words.delete();
        repeat (60) words.push_back(64'h0);
        do_reset();
        start_run();
        run_until(3000, 100, 100, 100, 1000, to);
        checks++;
        if (to || got_coef.size() != 100) $display("[TB] FAIL areset_reach: got %0d coefs expected 100", got_coef.size());
        else passes++;
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_ack, o_coef_valid, o_busy, o_done, o_coef, o_coef_idx} !== '0)
            $display("[TB] FAIL areset_outputs: got ack=%b v=%b busy=%b done=%b coef=%0d idx=%0d expected all 0",
                     o_ack, o_coef_valid, o_busy, o_done, o_coef, o_coef_idx);
        else passes++;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) $display("[TB] FAIL areset_idle: got busy=%b done=%b expected 0 0", o_busy, o_done);
        else passes++;
        start_run();
        run_until(3000, 100, 100, N + 1, 1000, to);
        checks++;
        if (to || got_coef.size() != N || acks !== words_needed)
            $display("[TB] FAIL areset_restart: got %0d coefs %0d acks expected %0d coefs %0d acks", got_coef.size(), acks, N, words_needed);
        else passes++;
        checks++;
        if (got_idx.size() == 0 || got_idx[0] !== 0)
            $display("[TB] FAIL areset_first_idx: got %0d expected 0", (got_idx.size() == 0) ? -1 : got_idx[0]);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_zero_words();
        test_all_ones();
        test_q_boundary();
        test_straddle();
        test_backpressure();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
